sa_autosa_sdp_wdma_req_pack: RTL and testbench
==============================================

SA_AUTOSA_SDP_WDMA_REQ_PACK -- requirements
Module: SA_AUTOSA_SDP_WDMA_req_pack

Interface
REQ-001 Parameter DW, default 256, is the data payload width in bits, one 32-byte atom per beat.
REQ-002 Parameter AW, default 32, is the DMA byte-address width.
REQ-003 Port autosa_core_clk, input, 1 bit: the single clock; there is one clock and all logic is on its rising edge.
REQ-004 Port autosa_core_rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port op_load, input, 1: single-cycle layer-start pulse.
REQ-006 Ports cmd_pvld (input, 1), cmd_prdy (output, 1) and cmd_pd (input, 46) carry the write command:
- [31:0] addr
- [44:32] size, meaning beats-1
- [45] last, marking the last command of the layer
REQ-007 Ports dat_pvld (input, 1), dat_prdy (output, 1) and dat_pd (input, DW) carry the datapath write data, one atom per beat.
REQ-008 Ports dma_wr_req_vld (output, 1), dma_wr_req_rdy (input, 1) and dma_wr_req_pd (output, DW+1) form the DMA write request:
- [DW] pkt type: 0 = cmd, 1 = dat
- cmd payload: [31:0] addr, [44:32] size, [45] require_ack, other bits 0
REQ-009 Port dma_wr_rsp_complete, input, 1: write-ack pulse.
REQ-010 Port wdma_done, output, 1: single-cycle layer-done pulse.
REQ-011 Port dp2reg_wdma_stall, output, 32: stall-cycle count.

Function
REQ-012 The FSM SHALL have states IDLE, CMD and DAT, with these transitions:
- IDLE to CMD on cmd_pvld.
- CMD to DAT on the cmd packet handshake.
- DAT to IDLE after the final beat handshake, with beat_cnt==size.
REQ-013 cmd_prdy SHALL be 1 only in IDLE and only while no cmd packet is pending; the command SHALL be registered on acceptance.
REQ-014 In CMD, dma_wr_req_vld SHALL be 1 with the registered cmd packet, and require_ack SHALL equal the registered last bit.
REQ-015 In DAT, the datapath SHALL be combinationally passed through:
- dma_wr_req_vld = dat_pvld
- dat_prdy = dma_wr_req_rdy
- pd = {1'b1, dat_pd}
REQ-016 Outside DAT, dat_prdy SHALL be 0; data arriving before its command stalls.
REQ-017 The 13-bit beat_cnt SHALL clear on entering DAT and increment per data handshake; size=0 yields exactly one data beat, and size=8191 yields 8192 beats with no wrap.
REQ-018 Once asserted, dma_wr_req_vld and dma_wr_req_pd SHALL hold stable until dma_wr_req_rdy is 1.
REQ-019 Latency from cmd accept to cmd packet valid SHALL be 1 cycle, and a new command SHALL be accepted in the cycle after the last data beat.
REQ-020 A 2-bit ack_pend counter SHALL behave as follows:
- It increments when a require_ack cmd packet handshakes.
- It decrements on dma_wr_rsp_complete.
- Simultaneous increment and decrement leave it unchanged.
- It does not underflow; a spurious ack at 0 is ignored.
REQ-021 A layer_last flag SHALL set when the last-command data phase completes and clear on op_load.
REQ-022 wdma_done SHALL pulse one cycle after the first cycle in which layer_last is set, ack_pend is 0 and the FSM is in IDLE, and SHALL pulse once per layer.
REQ-023 dp2reg_wdma_stall SHALL count cycles with dma_wr_req_vld && !dma_wr_req_rdy, saturate at 0xFFFFFFFF, and clear on op_load.
REQ-024 If op_load and a stall occur in the same cycle, the clear SHALL win and the count SHALL become 0.

Reset
REQ-025 While autosa_core_rstn is sampled 0, the following SHALL all be forced at the next edge, including mid-packet:
- FSM = IDLE
- beat_cnt = 0
- ack_pend = 0
- layer_last = 0
- cmd register = 0
- dp2reg_wdma_stall = 0
REQ-026 Output reset values SHALL be:
- cmd_prdy = 1
- dat_prdy = 0
- dma_wr_req_vld = 0
- dma_wr_req_pd = 0
- wdma_done = 0
REQ-027 Any DMA transaction interrupted by reset is abandoned and SHALL NOT be resumed.

Structure
REQ-028 The shared SDP package SHALL hold:
- packet-type constants PKT_CMD and PKT_DAT
- cmd field offsets and widths
- the FSM state typedef
REQ-029 The stall counter SHALL be one sub-module, SA_AUTOSA_SDP_sat_cnt32, which is saturating with synchronous clear; all other logic is flat.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Cmd addr=0x1000, size=3, last=1, rdy always 1 -> one cmd pkt with require_ack=1, then 4 dat pkts in order; after an ack pulse, wdma_done pulses once.
- size=0, last=0, twice -> pattern cmd, dat, cmd, dat; no wdma_done.
- dma_wr_req_rdy=0 for 5 cycles during the cmd phase -> vld/pd held stable; dp2reg_wdma_stall=5.
- Ack arriving in the same cycle the require_ack cmd handshakes -> ack_pend stays 0; done after the data phase.
- Reset asserted at beat 2 of 8 -> next cycle vld=0, state IDLE, cmd_prdy=1; a new command then completes normally.
- Spurious ack with ack_pend=0 -> no underflow, no wdma_done.

Source files
------------

// File: rtl/sa_autosa_sdp_wdma_req_pack_pkg.sv
// Shared SDP write-DMA definitions: packet-type codes, command field layout
// and the request-packer FSM state encoding.
package sa_autosa_sdp_wdma_req_pack_pkg;

   localparam logic PKT_CMD = 1'b0;
   localparam logic PKT_DAT = 1'b1;

   localparam int CMD_PD_W       = 46;
   localparam int CMD_ADDR_LSB   = 0;
   localparam int CMD_ADDR_W     = 32;
   localparam int CMD_SIZE_LSB   = 32;
   localparam int CMD_SIZE_W     = 13;
   localparam int CMD_LAST_BIT   = 45;
   localparam int CMD_REQACK_BIT = 45;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DAT  = 2'd2
   } wdma_state_e;

endpackage

// File: rtl/SA_AUTOSA_SDP_sat_cnt32.sv
// 32-bit event counter that sticks at all-ones; synchronous clear beats increment.
module SA_AUTOSA_SDP_sat_cnt32 (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_clr,
   input  logic        i_inc,
   output logic [31:0] o_cnt
);

   logic [31:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != 32'hFFFF_FFFF)) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/sa_autosa_sdp_wdma_req_pack.sv
// Packs SDP write commands and datapath atoms into one DMA write-request stream,
// tracks outstanding write acks and signals layer completion.
module sa_autosa_sdp_wdma_req_pack
   import sa_autosa_sdp_wdma_req_pack_pkg::*;
#(
   parameter int DW = 256,
   parameter int AW = 32
) (
   input  logic                autosa_core_clk,
   input  logic                autosa_core_rstn,
   input  logic                op_load,
   input  logic                cmd_pvld,
   output logic                cmd_prdy,
   input  logic [CMD_PD_W-1:0] cmd_pd,
   input  logic                dat_pvld,
   output logic                dat_prdy,
   input  logic [DW-1:0]       dat_pd,
   output logic                dma_wr_req_vld,
   input  logic                dma_wr_req_rdy,
   output logic [DW:0]         dma_wr_req_pd,
   input  logic                dma_wr_rsp_complete,
   output logic                wdma_done,
   output logic [31:0]         dp2reg_wdma_stall
);

   wdma_state_e             r_state;
   wdma_state_e             w_state_nxt;
   logic [AW-1:0]           r_cmd_addr;
   logic [CMD_SIZE_W-1:0]   r_cmd_size;
   logic                    r_cmd_last;
   logic [CMD_SIZE_W-1:0]   r_beat_cnt;
   logic [1:0]              r_ack_pend;
   logic                    r_layer_last;
   logic                    r_done_sent;
   logic                    r_wdma_done;
   logic [DW:0]             w_cmd_pkt;
   logic                    w_cmd_acc;
   logic                    w_cmd_hs;
   logic                    w_dat_hs;
   logic                    w_last_beat;
   logic                    w_ack_inc;
   logic                    w_ack_dec;
   logic                    w_done_cond;

   assign w_cmd_acc   = (r_state == ST_IDLE) && cmd_pvld;
   assign w_cmd_hs    = (r_state == ST_CMD) && dma_wr_req_rdy;
   assign w_dat_hs    = (r_state == ST_DAT) && dat_pvld && dma_wr_req_rdy;
   assign w_last_beat = (r_beat_cnt == r_cmd_size);
   assign w_ack_inc   = w_cmd_hs && r_cmd_last;
   assign w_ack_dec   = dma_wr_rsp_complete;
   assign w_done_cond = r_layer_last && (r_ack_pend == 2'd0) &&
                        (r_state == ST_IDLE) && !r_done_sent;

   always_comb begin
      w_cmd_pkt                                 = '0;
      w_cmd_pkt[DW]                             = PKT_CMD;
      w_cmd_pkt[CMD_ADDR_LSB +: AW]             = r_cmd_addr;
      w_cmd_pkt[CMD_SIZE_LSB +: CMD_SIZE_W]     = r_cmd_size;
      w_cmd_pkt[CMD_REQACK_BIT]                 = r_cmd_last;
   end

   always_comb begin
      w_state_nxt    = r_state;
      cmd_prdy       = 1'b0;
      dat_prdy       = 1'b0;
      dma_wr_req_vld = 1'b0;
      dma_wr_req_pd  = '0;
      case (r_state)
         ST_IDLE: begin
            cmd_prdy = 1'b1;
            if (cmd_pvld) w_state_nxt = ST_CMD;
         end
         ST_CMD: begin
            dma_wr_req_vld = 1'b1;
            dma_wr_req_pd  = w_cmd_pkt;
            if (dma_wr_req_rdy) w_state_nxt = ST_DAT;
         end
         ST_DAT: begin
            // Data is a pure pass-through; upstream holds it until accepted.
            dma_wr_req_vld = dat_pvld;
            dat_prdy       = dma_wr_req_rdy;
            dma_wr_req_pd  = {PKT_DAT, dat_pd};
            if (w_dat_hs && w_last_beat) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge autosa_core_clk) begin
      if (!autosa_core_rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge autosa_core_clk) begin
      if (!autosa_core_rstn) begin
         r_cmd_addr   <= '0;
         r_cmd_size   <= '0;
         r_cmd_last   <= 1'b0;
         r_beat_cnt   <= '0;
         r_ack_pend   <= 2'd0;
         r_layer_last <= 1'b0;
         r_done_sent  <= 1'b0;
         r_wdma_done  <= 1'b0;
      end else begin
         if (w_cmd_acc) begin
            r_cmd_addr <= cmd_pd[CMD_ADDR_LSB +: AW];
            r_cmd_size <= cmd_pd[CMD_SIZE_LSB +: CMD_SIZE_W];
            r_cmd_last <= cmd_pd[CMD_LAST_BIT];
         end
         // The final beat leaves the count at size, so size=8191 never wraps.
         if (w_cmd_hs) begin
            r_beat_cnt <= '0;
         end else if (w_dat_hs && !w_last_beat) begin
            r_beat_cnt <= r_beat_cnt + 13'd1;
         end
         case ({w_ack_inc, w_ack_dec})
            2'b10:   if (r_ack_pend != 2'd3) r_ack_pend <= r_ack_pend + 2'd1;
            2'b01:   if (r_ack_pend != 2'd0) r_ack_pend <= r_ack_pend - 2'd1;
            default: ;
         endcase
         if (op_load) begin
            r_layer_last <= 1'b0;
         end else if (w_dat_hs && w_last_beat && r_cmd_last) begin
            r_layer_last <= 1'b1;
         end
         if (op_load) begin
            r_done_sent <= 1'b0;
         end else if (w_done_cond) begin
            r_done_sent <= 1'b1;
         end
         r_wdma_done <= w_done_cond;
      end
   end

   assign wdma_done = r_wdma_done;

   SA_AUTOSA_SDP_sat_cnt32 u_stall_cnt (
      .i_clk  (autosa_core_clk),
      .i_rstn (autosa_core_rstn),
      .i_clr  (op_load),
      .i_inc  (dma_wr_req_vld && !dma_wr_req_rdy),
      .o_cnt  (dp2reg_wdma_stall)
   );

endmodule

// File: tb/tb_sa_autosa_sdp_wdma_req_pack.sv
// Directed bench for the SDP write-DMA request packer.
module tb_sa_autosa_sdp_wdma_req_pack;
   import sa_autosa_sdp_wdma_req_pack_pkg::*;

   localparam int DW = 256;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          op_load;
   logic          cmd_pvld;
   logic          cmd_prdy;
   logic [45:0]   cmd_pd;
   logic          dat_pvld;
   logic          dat_prdy;
   logic [DW-1:0] dat_pd;
   logic          vld;
   logic          rdy;
   logic [DW:0]   pd;
   logic          ack;
   logic          done;
   logic [31:0]   stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sa_autosa_sdp_wdma_req_pack #(.DW(DW), .AW(AW)) dut (
      .autosa_core_clk     (clk),
      .autosa_core_rstn    (rstn),
      .op_load             (op_load),
      .cmd_pvld            (cmd_pvld),
      .cmd_prdy            (cmd_prdy),
      .cmd_pd              (cmd_pd),
      .dat_pvld            (dat_pvld),
      .dat_prdy            (dat_prdy),
      .dat_pd              (dat_pd),
      .dma_wr_req_vld      (vld),
      .dma_wr_req_rdy      (rdy),
      .dma_wr_req_pd       (pd),
      .dma_wr_rsp_complete (ack),
      .wdma_done           (done),
      .dp2reg_wdma_stall   (stall)
   );

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pd(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_op_load();
      op_load = 1'b1;
      cyc();
      op_load = 1'b0;
   endtask

   function automatic logic [DW-1:0] dpat(input int i);
      dpat = {(DW/32){32'hA5A5_0000 ^ 32'(i)}};
   endfunction

   function automatic logic [DW:0] cpkt(input logic [31:0] addr, input logic [12:0] size,
                                        input logic last);
      cpkt        = '0;
      cpkt[45:0]  = {last, size, addr};
      cpkt[DW]    = 1'b0;
   endfunction

   initial begin
      logic [DW:0] exp_pkt;
      int          seen;

      rstn = 1'b0; op_load = 1'b0; cmd_pvld = 1'b0; cmd_pd = '0;
      dat_pvld = 1'b0; dat_pd = '0; rdy = 1'b0; ack = 1'b0;
      repeat (3) cyc();
      #1;
      chk_b("rst_cmd_prdy", cmd_prdy, 1'b1);
      chk_b("rst_dat_prdy", dat_prdy, 1'b0);
      chk_b("rst_vld", vld, 1'b0);
      chk_pd("rst_pd", pd, '0);
      chk_b("rst_done", done, 1'b0);
      chk_w("rst_stall", stall, 32'd0);
      rstn = 1'b1;
      cyc();

      // Scenario 1: addr 0x1000, size 3, last 1, rdy always high
      pulse_op_load();
      rdy = 1'b1; cmd_pvld = 1'b1; cmd_pd = {1'b1, 13'd3, 32'h0000_1000};
      #1;
      chk_b("s1_cmd_prdy", cmd_prdy, 1'b1);
      cyc();
      cmd_pvld = 1'b0; cmd_pd = '0;
      #1;
      exp_pkt = cpkt(32'h0000_1000, 13'd3, 1'b1);
      chk_b("s1_cmd_vld", vld, 1'b1);
      chk_pd("s1_cmd_pkt", pd, exp_pkt);
      chk_b("s1_cmd_prdy_busy", cmd_prdy, 1'b0);
      chk_b("s1_dat_prdy_in_cmd", dat_prdy, 1'b0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         dat_pvld = 1'b1; dat_pd = dpat(i);
         #1;
         chk_b("s1_dat_vld", vld, 1'b1);
         chk_b("s1_dat_prdy", dat_prdy, 1'b1);
         chk_pd("s1_dat_pkt", pd, {1'b1, dpat(i)});
         cyc();
      end
      dat_pvld = 1'b0;
      #1;
      chk_b("s1_idle_cmd_prdy", cmd_prdy, 1'b1);
      chk_b("s1_no_done_before_ack", done, 1'b0);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      #1;
      chk_b("s1_done_latency", done, 1'b0);
      cyc();
      chk_b("s1_done_pulse", done, 1'b1);
      cyc();
      chk_b("s1_done_single", done, 1'b0);
      cyc();
      chk_b("s1_done_once", done, 1'b0);

      // Scenario 2: two size-0, last-0 commands back to back
      pulse_op_load();
      for (int k = 0; k < 2; k++) begin
         cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'd0, 32'h0000_2000 + 32'(k * 32)};
         #1;
         chk_b("s2_cmd_prdy", cmd_prdy, 1'b1);
         cyc();
         cmd_pvld = 1'b0;
         #1;
         chk_pd("s2_cmd_pkt", pd, cpkt(32'h0000_2000 + 32'(k * 32), 13'd0, 1'b0));
         cyc();
         dat_pvld = 1'b1; dat_pd = dpat(100 + k);
         #1;
         chk_pd("s2_dat_pkt", pd, {1'b1, dpat(100 + k)});
         cyc();
         dat_pvld = 1'b0;
      end
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) seen++;
         cyc();
      end
      chk_w("s2_no_done", 32'(seen), 32'd0);

      // Scenario 3: cmd phase back-pressured for 5 cycles, then clear-vs-stall race
      pulse_op_load();
      chk_w("s3_stall_cleared", stall, 32'd0);
      rdy = 1'b0; cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'd0, 32'h0000_3000};
      cyc();
      cmd_pvld = 1'b0;
      exp_pkt = cpkt(32'h0000_3000, 13'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_b("s3_hold_vld", vld, 1'b1);
         chk_pd("s3_hold_pd", pd, exp_pkt);
         cyc();
      end
      chk_w("s3_stall_5", stall, 32'd5);
      op_load = 1'b1;
      cyc();
      op_load = 1'b0;
      #1;
      chk_w("s3_clear_wins", stall, 32'd0);
      chk_pd("s3_hold_after_clear", pd, exp_pkt);
      rdy = 1'b1;
      cyc();
      dat_pvld = 1'b1; dat_pd = dpat(9);
      #1;
      chk_pd("s3_dat_pkt", pd, {1'b1, dpat(9)});
      cyc();
      dat_pvld = 1'b0;
      #1;
      chk_b("s3_back_idle", cmd_prdy, 1'b1);
      chk_w("s3_stall_kept", stall, 32'd0);

      // Scenario 4: ack coincides with the require_ack cmd handshake
      pulse_op_load();
      cmd_pvld = 1'b1; cmd_pd = {1'b1, 13'd1, 32'h0000_4000};
      cyc();
      cmd_pvld = 1'b0; ack = 1'b1;
      #1;
      chk_pd("s4_cmd_pkt", pd, cpkt(32'h0000_4000, 13'd1, 1'b1));
      cyc();
      ack = 1'b0;
      #1;
      chk_w("s4_ack_pend_zero", 32'(dut.r_ack_pend), 32'd0);
      for (int i = 0; i < 2; i++) begin
         dat_pvld = 1'b1; dat_pd = dpat(20 + i);
         cyc();
      end
      dat_pvld = 1'b0;
      #1;
      chk_b("s4_done_latency", done, 1'b0);
      cyc();
      chk_b("s4_done_pulse", done, 1'b1);
      cyc();
      chk_b("s4_done_single", done, 1'b0);

      // Scenario 5: reset in the middle of an 8-beat data phase
      pulse_op_load();
      cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'd7, 32'h0000_5000};
      cyc();
      cmd_pvld = 1'b0;
      cyc();
      for (int i = 0; i < 2; i++) begin
         dat_pvld = 1'b1; dat_pd = dpat(30 + i);
         cyc();
      end
      dat_pd = dpat(32); rstn = 1'b0;
      #1;
      chk_b("s5_beat2_vld", vld, 1'b1);
      cyc();
      rstn = 1'b1;
      #1;
      chk_b("s5_rst_vld", vld, 1'b0);
      chk_pd("s5_rst_pd", pd, '0);
      chk_b("s5_rst_dat_prdy", dat_prdy, 1'b0);
      chk_b("s5_rst_cmd_prdy", cmd_prdy, 1'b1);
      chk_w("s5_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
      chk_w("s5_rst_beat_cnt", 32'(dut.r_beat_cnt), 32'd0);
      dat_pvld = 1'b0;
      cmd_pvld = 1'b1; cmd_pd = {1'b1, 13'd1, 32'h0000_6000};
      cyc();
      cmd_pvld = 1'b0;
      #1;
      chk_pd("s5_new_cmd_pkt", pd, cpkt(32'h0000_6000, 13'd1, 1'b1));
      cyc();
      for (int i = 0; i < 2; i++) begin
         dat_pvld = 1'b1; dat_pd = dpat(40 + i);
         #1;
         chk_pd("s5_new_dat_pkt", pd, {1'b1, dpat(40 + i)});
         cyc();
      end
      dat_pvld = 1'b0; ack = 1'b1;
      #1;
      chk_b("s5_no_done_pending", done, 1'b0);
      cyc();
      ack = 1'b0;
      cyc();
      chk_b("s5_done_pulse", done, 1'b1);
      cyc();
      chk_b("s5_done_single", done, 1'b0);

      // Scenario 6: spurious ack with nothing outstanding
      pulse_op_load();
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      #1;
      chk_w("s6_no_underflow", 32'(dut.r_ack_pend), 32'd0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) seen++;
         cyc();
      end
      chk_w("s6_no_done", 32'(seen), 32'd0);

      // Scenario 7: maximum size, 8192 beats without wrap
      pulse_op_load();
      cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'h1FFF, 32'h0000_7000};
      cyc();
      cmd_pvld = 1'b0;
      #1;
      chk_pd("s7_cmd_pkt", pd, cpkt(32'h0000_7000, 13'h1FFF, 1'b0));
      cyc();
      dat_pvld = 1'b1;
      for (int i = 0; i < 8191; i++) begin
         dat_pd = dpat(i);
         cyc();
      end
      dat_pd = dpat(8191);
      #1;
      chk_b("s7_still_dat", dat_prdy, 1'b1);
      chk_b("s7_still_busy", cmd_prdy, 1'b0);
      chk_w("s7_beat_cnt_max", 32'(dut.r_beat_cnt), 32'h1FFF);
      cyc();
      dat_pvld = 1'b0;
      #1;
      chk_b("s7_end_idle", cmd_prdy, 1'b1);
      chk_b("s7_end_dat_prdy", dat_prdy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
